// File: rtl/dll_pkg.sv
// Shared data-link-layer types and field positions for the replay path.
// A framed TLP is {4'b0, seq[11:0], body[95:0], lcrc[15:0]}.
package dll_pkg;

  localparam int SEQ_W  = 12;
  localparam int TLP_W  = 128;
  localparam int SEQ_HI = 123;
  localparam int SEQ_LO = 112;
  localparam int LCRC_W = 16;

  typedef enum logic {
    SEND   = 1'b0,
    REPLAY = 1'b1
  } dll_state_e;

  function automatic logic [SEQ_W-1:0] tlp_seq(input logic [TLP_W-1:0] tlp);
    return tlp[SEQ_HI:SEQ_LO];
  endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timer: down-counter reloaded on clear.
// expire asserts on the cycle REPLAY_TIMEOUT-1 cycles of run have elapsed.
module replay_timer #(
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(REPLAY_TIMEOUT);
  localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(REPLAY_TIMEOUT - 1);

  logic [CNT_W-1:0] remain;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      remain <= TC_LOAD;
    end else if (run && (remain != '0)) begin
      remain <= remain - 1'b1;
    end
  end

  assign expire = run && (remain == '0);

endmodule

// File: rtl/replay_buffer.sv
// Replay buffer: holds framed TLPs until ACKed, streams them to the PHY,
// and retransmits the unacknowledged window on NAK or replay-timer expiry.
//   state  | meaning
//   SEND   | accept new TLPs and stream them in order
//   REPLAY | no new writes; resend ack_ptr..replay_end-1
module replay_buffer
  import dll_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlp_valid,
  input  logic [TLP_W-1:0] tlp_in,
  output logic             tlp_ready,
  output logic             tx_valid,
  output logic [TLP_W-1:0] tx_data,
  input  logic             tx_ready,
  input  logic             dllp_valid,
  input  logic             dllp_ack,
  input  logic [SEQ_W-1:0] dllp_seq,
  output logic             replaying,
  output logic             retrain_req
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TLP_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr, tx_ptr, ack_ptr, replay_end;
  logic [PW-1:0] count, ack_nxt, tx_mid, tx_fix;
  logic [SEQ_W-1:0] oldest_seq, purge_n;
  logic [1:0] replay_num, num_base;
  dll_state_e state;
  logic wr_en, tx_adv, full, purge_ok, nak, expire, replay_start, passes;

  assign count     = wr_ptr - ack_ptr;
  assign full      = (count == PW'(DEPTH));
  assign tlp_ready = !full && (state == SEND);
  assign tx_valid  = (tx_ptr != wr_ptr);
  assign tx_data   = mem[tx_ptr[AW-1:0]];
  assign replaying = (state == REPLAY);

  assign wr_en  = tlp_valid && tlp_ready;
  assign tx_adv = tx_valid && tx_ready;
  assign tx_mid = tx_ptr + PW'(tx_adv);

  // Sequence distance is modulo 4096, so stale/duplicate DLLPs land outside 1..count.
  assign oldest_seq = tlp_seq(mem[ack_ptr[AW-1:0]]);
  assign purge_n    = dllp_seq - oldest_seq + 1'b1;
  assign purge_ok   = dllp_valid && (count != '0) && (purge_n != '0)
                      && (purge_n <= SEQ_W'(count));
  assign ack_nxt    = purge_ok ? (ack_ptr + PW'(purge_n)) : ack_ptr;

  assign nak          = dllp_valid && !dllp_ack;
  assign replay_start = nak || ((state == SEND) && expire);

  // Distances from the old ack_ptr tell whether the purge overtook tx_ptr.
  assign passes = (ack_nxt - ack_ptr) > (tx_mid - ack_ptr);
  assign tx_fix = passes ? ack_nxt : tx_mid;

  assign num_base = purge_ok ? 2'd0 : replay_num;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= tlp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      tx_ptr      <= '0;
      ack_ptr     <= '0;
      replay_end  <= '0;
      replay_num  <= 2'd0;
      retrain_req <= 1'b0;
      state       <= SEND;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      ack_ptr     <= ack_nxt;
      replay_num  <= num_base;
      retrain_req <= 1'b0;
      if (replay_start) begin
        tx_ptr      <= ack_nxt;
        replay_num  <= num_base + 2'd1;
        retrain_req <= (num_base == 2'd3);
        state       <= REPLAY;
        // A NAK during replay keeps the original end of the window.
        if (state == SEND) begin
          replay_end <= tx_mid;
        end
      end else begin
        tx_ptr <= tx_fix;
        if ((state == REPLAY) && (tx_ptr == replay_end)) begin
          state <= SEND;
        end
      end
    end
  end

  replay_timer #(
    .REPLAY_TIMEOUT(REPLAY_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    ((state == SEND) && (count != '0)),
    .clear  (purge_ok || replay_start || (count == '0)),
    .expire (expire)
  );

endmodule

// File: tb/tb_replay_buffer.sv
// Directed bench for replay_buffer: streaming, full/ACK, NAK replay,
// timer replay with retrain rollover, sequence wrap and reset during replay.
module tb_replay_buffer;

  logic         clk;
  logic         rst;
  logic         tlp_valid;
  logic [127:0] tlp_in;
  logic         tlp_ready;
  logic         tx_valid;
  logic [127:0] tx_data;
  logic         tx_ready;
  logic         dllp_valid;
  logic         dllp_ack;
  logic [11:0]  dllp_seq;
  logic         replaying;
  logic         retrain_req;

  int n_checks = 0;
  int n_fail   = 0;

  replay_buffer #(
    .DEPTH          (8),
    .REPLAY_TIMEOUT (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tlp_valid   (tlp_valid),
    .tlp_in      (tlp_in),
    .tlp_ready   (tlp_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .dllp_valid  (dllp_valid),
    .dllp_ack    (dllp_ack),
    .dllp_seq    (dllp_seq),
    .replaying   (replaying),
    .retrain_req (retrain_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [11:0] s);
    return {4'h0, s, {8{s}}, 4'hA, ~s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    tlp_valid  = 1'b0;
    tlp_in     = '0;
    tx_ready   = 1'b0;
    dllp_valid = 1'b0;
    dllp_ack   = 1'b0;
    dllp_seq   = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_seq(input logic [11:0] s);
    tlp_valid = 1'b1;
    tlp_in    = mk(s);
    step();
    tlp_valid = 1'b0;
  endtask

  task automatic send_dllp(input logic ack, input logic [11:0] s);
    dllp_valid = 1'b1;
    dllp_ack   = ack;
    dllp_seq   = s;
    step();
    dllp_valid = 1'b0;
  endtask

  initial begin
    int retrains;
    int w;

    // reset state
    do_reset();
    check("rst_tlp_ready", tlp_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_replaying", replaying, 0);
    check("rst_retrain", retrain_req, 0);
    check("rst_count", dut.count, 0);

    // 1: streaming seq 1..3 back to back
    tx_ready  = 1'b1;
    tlp_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tlp_in = mk(12'(i));
      step();
      check("t1_tx_valid", tx_valid, 1);
      check("t1_tx_data", tx_data, mk(12'(i)));
    end
    tlp_valid = 1'b0;
    check("t1_count", dut.count, 3);
    step();
    check("t1_drained", tx_valid, 0);

    // 2: fill, full blocks writes, ACK 4 frees four entries
    do_reset();
    for (int i = 1; i <= 8; i++) write_seq(12'(i));
    check("t2_full_ready", tlp_ready, 0);
    check("t2_full_count", dut.count, 8);
    write_seq(12'd9);
    check("t2_overfill", dut.count, 8);
    send_dllp(1'b1, 12'd4);
    check("t2_ack_ptr", dut.ack_ptr, 4);
    check("t2_ready", tlp_ready, 1);
    check("t2_count", dut.count, 4);

    // 3: NAK seq 2 purges 1,2 and replays 3,4,5
    do_reset();
    tx_ready = 1'b1;
    for (int i = 1; i <= 5; i++) write_seq(12'(i));
    step();
    check("t3_sent", tx_valid, 0);
    send_dllp(1'b0, 12'd2);
    check("t3_replaying", replaying, 1);
    check("t3_count", dut.count, 3);
    check("t3_no_write", tlp_ready, 0);
    for (int i = 3; i <= 5; i++) begin
      check("t3_replay_data", tx_data, mk(12'(i)));
      check("t3_replay_valid", tx_valid, 1);
      step();
    end
    check("t3_done_valid", tx_valid, 0);
    step();
    check("t3_back_send", replaying, 0);
    check("t3_ready", tlp_ready, 1);

    // 4: timer replay of seq 1, retrain on the fourth expiry
    do_reset();
    tx_ready = 1'b1;
    write_seq(12'd1);
    retrains = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!replaying && w < 1200) begin
        step();
        w++;
        if (retrain_req) retrains++;
      end
      check("t4_replay", replaying, 1);
      check("t4_period", (w >= 1010 && w <= 1040), 1);
      check("t4_data", tx_data, mk(12'd1));
      check("t4_retrain", retrain_req, (k == 3));
      w = 0;
      while (replaying && w < 20) begin
        step();
        w++;
        if (retrain_req) retrains++;
      end
      check("t4_replay_end", replaying, 0);
    end
    check("t4_retrain_total", retrains, 1);

    // 5: sequence wrap and stale ACKs
    do_reset();
    tx_ready = 1'b1;
    write_seq(12'd4094);
    write_seq(12'd4095);
    write_seq(12'd0);
    send_dllp(1'b1, 12'd0);
    check("t5_wrap_count", dut.count, 0);
    check("t5_wrap_ack", dut.ack_ptr, 3);
    send_dllp(1'b1, 12'd4093);
    check("t5_stale_empty", dut.ack_ptr, 3);
    write_seq(12'd1);
    send_dllp(1'b1, 12'd4093);
    check("t5_stale_count", dut.count, 1);
    send_dllp(1'b1, 12'd1);
    check("t5_ack1_count", dut.count, 0);

    // 6: reset while replaying five entries
    do_reset();
    tx_ready = 1'b1;
    for (int i = 1; i <= 5; i++) write_seq(12'(i));
    step();
    tx_ready = 1'b0;
    send_dllp(1'b0, 12'd0);
    check("t6_replaying", replaying, 1);
    check("t6_count", dut.count, 5);
    check("t6_data", tx_data, mk(12'd1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_tx_valid", tx_valid, 0);
    check("t6_ready", tlp_ready, 1);
    check("t6_replaying_off", replaying, 0);
    check("t6_count_zero", dut.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
